// File: rtl/exec_unit.sv
`default_nettype none
// exec_unit: integer execute stage with single-cycle base ALU ops and an optional
// iterative multiply/divide unit enabled by EXEC_UNIT_MULDIV_EN.
module exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_funct3,
  input  logic             op_alt,
  input  logic             op_m,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_err,
  output logic             busy
);
  logic                    accept;
  logic [WIDTH-1:0]        alu_res;
  logic signed [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_err_q, out_err_d;
  logic                    m_load, m_err;
  logic [WIDTH-1:0]        m_res;

  assign in_ready  = !resetn && !busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

  // Kept as its own signed signal so the arithmetic shift is not made unsigned by context.
  assign sra_res = $signed(x) >>> y[SHW-1:0];

  always_comb begin : alu
    alu_res = '0;
    case (op_funct3)
      3'b000:  alu_res = op_alt ? (x - y) : (x + y);
      3'b001:  alu_res = x << y[SHW-1:0];
      3'b010:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      3'b011:  alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
      3'b100:  alu_res = x ^ y;
      3'b101: begin
        if (op_alt) alu_res = sra_res;
        else        alu_res = x >> y[SHW-1:0];
      end
      3'b110:  alu_res = x | y;
      default: alu_res = x & y;
    endcase
  end

`ifdef EXEC_UNIT_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [WIDTH-1:0]   a_q, a_d, x_q, x_d;
  logic [2:0]         f_q, f_d;
  logic               neg_q, neg_d, yz_q, yz_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               x_sgn, y_sgn, x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag, y_mag, div_mag, div_res;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;

  // Operate on magnitudes; the result sign is reapplied in DONE.
  assign x_sgn   = (op_funct3 == 3'b001) || (op_funct3 == 3'b010) ||
                   (op_funct3 == 3'b100) || (op_funct3 == 3'b110);
  assign y_sgn   = (op_funct3 == 3'b001) || (op_funct3 == 3'b100) || (op_funct3 == 3'b110);
  assign x_neg   = x_sgn && x[WIDTH-1];
  assign y_neg   = y_sgn && y[WIDTH-1];
  assign x_mag   = x_neg ? -x : x;
  assign y_mag   = y_neg ? -y : y;

  // p_q holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, a_q};

  assign prod    = neg_q ? -p_q : p_q;
  assign div_mag = f_q[1] ? p_q[2*WIDTH-1:WIDTH] : p_q[WIDTH-1:0];
  assign div_res = neg_q ? -div_mag : div_mag;

  always_comb begin : m_result
    m_res = div_res;
    if (!f_q[2])   m_res = (f_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (yz_q) m_res = f_q[1] ? x_q : '1;
  end

  assign m_load = (state_q == S_DONE);
  assign m_err  = 1'b0;
  assign busy   = (state_q != S_IDLE);

  always_comb begin : fsm_next
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    x_d     = x_q;
    f_d     = f_q;
    neg_d   = neg_q;
    yz_d    = yz_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && op_m) begin
          state_d = op_funct3[2] ? S_DIV : S_MUL;
          a_d     = op_funct3[2] ? y_mag : x_mag;
          p_d     = {{WIDTH{1'b0}}, (op_funct3[2] ? x_mag : y_mag)};
          x_d     = x;
          f_d     = op_funct3;
          neg_d   = (op_funct3 == 3'b110) ? x_neg : (x_neg ^ y_neg);
          yz_d    = (y == '0);
          cnt_d   = '0;
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL)    p_d = {mul_sum, p_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH]) p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else                     p_d = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      a_q     <= '0;
      x_q     <= '0;
      f_q     <= '0;
      neg_q   <= 1'b0;
      yz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      x_q     <= x_d;
      f_q     <= f_d;
      neg_q   <= neg_d;
      yz_q    <= yz_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign m_load = accept && op_m;
  assign m_res  = '0;
  assign m_err  = 1'b1;
  assign busy   = 1'b0;
`endif

  always_comb begin : out_next
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !op_m) begin
      out_d       = alu_res;
      out_err_d   = 1'b0;
      out_valid_d = 1'b1;
    end else if (m_load) begin
      out_d       = m_res;
      out_err_d   = m_err;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// tb_exec_unit: scoreboard bench for exec_unit at WIDTH=32; expected {err, out}
// pairs are queued at issue and popped on each output handshake.
module tb_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, in_valid, in_ready, op_alt, op_m;
  logic         out_valid, out_ready, out_err, busy;
  logic [2:0]   op_funct3;
  logic [W-1:0] x, y, out;
  int           total = 0;
  int           bad = 0;
  logic [W:0]   sb[$];
  logic [W:0]   exp_v;
  logic         busy_seen = 1'b0;

  typedef struct packed {
    logic [2:0]   f;
    logic         alt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;

  vec_t bv [0:13] = '{
    '{3'b000, 1'b0, 32'd5,         32'd7,         32'd12},
    '{3'b000, 1'b1, 32'd3,         32'd5,         32'hFFFFFFFE},
    '{3'b101, 1'b1, 32'h80000000,  32'd4,         32'hF8000000},
    '{3'b101, 1'b0, 32'h80000000,  32'd4,         32'h08000000},
    '{3'b010, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd1},
    '{3'b011, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0},
    '{3'b001, 1'b0, 32'd1,         32'h23,        32'd8},
    '{3'b100, 1'b0, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFF00FF00},
    '{3'b110, 1'b0, 32'hF0000000,  32'h0000000F,  32'hF000000F},
    '{3'b111, 1'b0, 32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00},
    '{3'b000, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0},
    '{3'b100, 1'b1, 32'hAAAAAAAA,  32'h55555555,  32'hFFFFFFFF},
    '{3'b010, 1'b0, 32'h7FFFFFFF,  32'h80000000,  32'd0},
    '{3'b011, 1'b0, 32'h7FFFFFFF,  32'h80000000,  32'd1}
  };

`ifdef EXEC_UNIT_MULDIV_EN
  vec_t mv [0:12] = '{
    '{3'b101, 1'b0, 32'd100,       32'd7,         32'd14},
    '{3'b110, 1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF},
    '{3'b100, 1'b0, 32'd5,         32'd0,         32'hFFFFFFFF},
    '{3'b111, 1'b0, 32'd5,         32'd0,         32'd5},
    '{3'b100, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000},
    '{3'b001, 1'b0, 32'h80000000,  32'h80000000,  32'h40000000},
    '{3'b000, 1'b0, 32'd7,         32'd6,         32'd42},
    '{3'b011, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE},
    '{3'b010, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF},
    '{3'b100, 1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD},
    '{3'b110, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0},
    '{3'b101, 1'b0, 32'hFFFFFFFF,  32'd10,        32'h19999999},
    '{3'b110, 1'b0, 32'd7,         32'hFFFFFFFE,  32'd1}
  };
`endif

  exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_funct3 (op_funct3),
    .op_alt    (op_alt),
    .op_m      (op_m),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [2:0] f, input logic alt,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = 1'b1;
    op_m      = m;
    op_funct3 = f;
    op_alt    = alt;
    x         = a;
    y         = b;
  endtask

  task automatic test_reset;
    resetn    = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 32'd5, 32'd7);
    repeat (3) step();
    total++;
    if (out !== '0 || out_valid !== 1'b0 || out_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: out=%h valid=%b err=%b busy=%b, want all zero",
               out, out_valid, out_err, busy);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    resetn = 1'b0;
    #1;
    sb.push_back({1'b0, 32'd12});
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL first_accept_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
      bad++;
      $display("FAIL first_add: valid=%b got %h want %h", out_valid, {out_err, out}, exp_v);
    end
    step();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, bv[i].f, bv[i].alt, bv[i].a, bv[i].b);
      sb.push_back({1'b0, bv[i].r});
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
        bad++;
        $display("FAIL base_op[%0d]: valid=%b got %h want %h", i, out_valid, {out_err, out}, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_clears: got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd1, 32'd2);
    sb.push_back({1'b0, 32'd3});
    step();
    drive(1'b0, 3'b000, 1'b0, 32'd10, 32'd20);
    sb.push_back({1'b0, 32'd30});
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_err, out} !== sb[0]) begin
        bad++;
        $display("FAIL hold[%0d]: ready=%b valid=%b got %h want ready=0 valid=1 %h",
                 i, in_ready, out_valid, {out_err, out}, sb[0]);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
      bad++;
      $display("FAIL held_result: valid=%b got %h want %h", out_valid, {out_err, out}, exp_v);
    end
    step();
    in_valid = 1'b0;
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
      bad++;
      $display("FAIL second_result: valid=%b got %h want %h", out_valid, {out_err, out}, exp_v);
    end
    step();
  endtask

`ifdef EXEC_UNIT_MULDIV_EN
  task automatic test_muldiv;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, mv[i].f, 1'b0, mv[i].a, mv[i].b);
      sb.push_back({1'b0, mv[i].r});
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL m_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      x = $urandom;
      y = $urandom;
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL m_busy[%0d]: got %b want 1", i, busy);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
        step();
        lat++;
      end
      total++;
      if (lat != W + 1) begin
        bad++;
        $display("FAIL m_latency[%0d]: got %0d want %0d", i, lat, W + 1);
      end
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
        bad++;
        $display("FAIL m_op[%0d]: valid=%b got %h want %h", i, out_valid, {out_err, out}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_abort;
    logic seen;
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 1'b0, 32'd100, 32'd7);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    resetn = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_now: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    step();
    resetn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_result: activity=%b want 0", seen);
    end
    drive(1'b0, 3'b000, 1'b0, 32'd2, 32'd3);
    sb.push_back({1'b0, 32'd5});
    step();
    in_valid = 1'b0;
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
      bad++;
      $display("FAIL after_abort_add: valid=%b got %h want %h", out_valid, {out_err, out}, exp_v);
    end
    step();
  endtask
`else
  task automatic test_m_disabled;
    logic [2:0] fs [0:3] = '{3'b000, 3'b011, 3'b100, 3'b111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fs[i], 1'b0, 32'd123, 32'd456);
      sb.push_back({1'b1, 32'd0});
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL m_off_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || {out_err, out} !== exp_v || busy !== 1'b0) begin
        bad++;
        $display("FAIL m_off[%0d]: valid=%b busy=%b got %h want %h",
                 i, out_valid, busy, {out_err, out}, exp_v);
      end
    end
    drive(1'b0, 3'b000, 1'b0, 32'd2, 32'd2);
    sb.push_back({1'b0, 32'd4});
    step();
    in_valid = 1'b0;
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || {out_err, out} !== exp_v) begin
      bad++;
      $display("FAIL err_clears: valid=%b got %h want %h", out_valid, {out_err, out}, exp_v);
    end
    step();
    total++;
    if (busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL busy_never: got %b want 0", busy_seen);
    end
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    op_m      = 1'b0;
    op_funct3 = 3'b000;
    op_alt    = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_backpressure();
`ifdef EXEC_UNIT_MULDIV_EN
    test_muldiv();
    test_abort();
`else
    test_m_disabled();
`endif
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001: SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are powers of two, 8 or more.
REQ-002: SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width, derived only and never overridden.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: resetn  input  1  reset; asynchronous, active-high (asserted = 1) despite the name.
REQ-005: in_valid  input  1  operation offered.
REQ-006: in_ready  output  1  operation accepted this cycle when in_valid=1.
REQ-007: op_funct3  input  3  operation select.
REQ-008: op_alt  input  1  alternate op (SUB/SRA); ignored for other ops.
REQ-009: op_m  input  1  selects multiply/divide op set.
REQ-010: x, y  input  WIDTH each  operands.
REQ-011: out_valid  output  1  result available.
REQ-012: out_ready  input  1  consumer takes result.
REQ-013: out  output  WIDTH  result, registered.
REQ-014: out_err  output  1  op unsupported in this build, registered.
REQ-015: busy  output  1  multi-cycle op in progress.

Function
REQ-016: Accept SHALL occur when in_valid && in_ready, with in_ready = !resetn && !busy && (!out_valid || out_ready).
REQ-017: Base ops (op_m=0), by op_funct3: 000 ADD or SUB (op_alt=1); 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL or SRA (op_alt=1); 110 OR; 111 AND. Shift amount = y[SHW-1:0]. SLT/SLTU yield 0 or 1, zero-extended.
REQ-018: Base ops SHALL have latency 1: out and out_valid are set on the edge after accept.
REQ-019: out, out_err and out_valid SHALL hold unchanged while out_valid=1 && out_ready=0; out_valid SHALL clear on out_ready unless a new result loads on the same edge.
REQ-020: Simultaneous out_ready and a new accept SHALL load the new base result back-to-back, giving 1 op/cycle throughput.
REQ-021: Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-022: M ops run through FSM states IDLE -> MUL or DIV -> DONE -> IDLE.
  - Accept goes to MUL for 0xx, DIV for 1xx.
  - busy=1 in MUL, DIV and DONE.
  - DONE loads out and sets out_valid, then returns to IDLE.
REQ-023: M ops SHALL take exactly WIDTH+1 cycles from the accept edge to out_valid=1 (WIDTH iterations plus DONE), independent of operand values.
REQ-024: M ops by op_funct3: 000 MUL low half; 001 MULH s*s; 010 MULHSU s*u; 011 MULHU u*u (high halves); 100 DIV; 101 DIVU; 110 REM; 111 REMU. Division truncates toward zero; remainder takes the sign of the dividend.
REQ-025: Divide by zero: quotient all-ones, remainder = x, out_err=0.
REQ-026: Signed overflow (x = most-negative, y = -1): DIV result = x, REM result = 0.
REQ-027: Operands SHALL be captured at accept; input changes during busy have no effect.

Reset
REQ-028: While resetn=1: out=0, out_valid=0, out_err=0, busy=0, FSM=IDLE, in_ready=0.
REQ-029: Reset asserted mid-operation SHALL abort the operation immediately (asynchronous); no partial result is ever presented.
REQ-030: The first accept is possible on the first rising edge after resetn deasserts.

Configuration
REQ-031: Macro EXEC_UNIT_MULDIV_EN defined: REQ-022..REQ-026 are implemented.
REQ-032: Macro undefined:
  - op_m=1 SHALL complete with latency 1, out=0, out_err=1.
  - busy is constant 0.
  - No multiply/divide logic is synthesised.

Verification (WIDTH=32)
REQ-033: ADD x=5, y=7 -> out=12, out_valid=1 one cycle after accept; SUB x=3, y=5 -> 0xFFFFFFFE.
REQ-034: SRA x=0x80000000, y=4 -> 0xF8000000; SRL same operands -> 0x08000000; SLT x=-1, y=1 -> 1; SLTU same operands -> 0.
REQ-035: out_ready=0 with two back-to-back in_valid -> first result held stable, second not accepted (in_ready=0); out_ready=1 -> second accepted on that edge, its result valid next cycle.
REQ-036: (MULDIV_EN) DIVU 100/7 -> 14 exactly 33 cycles after accept; REM -7 % 2 -> 0xFFFFFFFF; DIV 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5; DIV 0x80000000/-1 -> 0x80000000; MULH 0x80000000*0x80000000 -> 0x40000000.
REQ-037: (MULDIV_EN) resetn pulsed at cycle 10 of a DIV -> busy=0, out_valid=0 immediately, no result emitted; next ADD completes normally.
REQ-038: (macro undefined) op_m=1, op_funct3=000 -> out=0, out_err=1, one cycle after accept; busy never 1.
